// File: rtl/m_s_to_p.sv
// Serial-to-parallel receiver: rebuilds MSB-first serial frames into WORD-bit words
// on a valid/ready output. Define M_S_TO_P_PARITY_EN to add a trailing even-parity bit.
module m_s_to_p #(
  parameter int WORD  = 8,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_i,
  input  logic            start_i,
  input  logic            sample_en,
  input  logic            err_clr,
  input  logic            o_ready,
  output logic [WORD-1:0] data_o,
  output logic            valid_o,
  output logic            busy,
  output logic            overrun_err,
  output logic            parity_err
);

`ifdef M_S_TO_P_PARITY_EN
  localparam int FRAME_BITS = WORD + 1;
`else
  localparam int FRAME_BITS = WORD;
`endif

  // Count value held while waiting for the frame's final bit.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [WORD-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
`ifdef M_S_TO_P_PARITY_EN
  logic              par_q, par_d;
  logic              word_par;
`endif

  logic              new_start;
  logic              frame_done;
  logic              ovr_event;
  logic [WORD-1:0]   word;

  assign new_start = sample_en & start_i;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through this block can infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    ovr_d      = ovr_q;
    frame_done = 1'b0;
    ovr_event  = 1'b0;
    word       = shift_q;
`ifdef M_S_TO_P_PARITY_EN
    par_d      = par_q;
    word_par   = 1'b0;
`endif

    // A start tick always begins a fresh frame, discarding any partial word.
    if (new_start) begin
      shift_d = {{(WORD-1){1'b0}}, data_i};
      cnt_d   = CNT_W'(1);
      state_d = SHIFT;
      busy_d  = 1'b1;
    end else if (state_q == SHIFT && sample_en) begin
      if (cnt_q == LAST_CNT) begin
        frame_done = 1'b1;
        state_d    = IDLE;
        busy_d     = 1'b0;
        cnt_d      = '0;
`ifdef M_S_TO_P_PARITY_EN
        word       = shift_q;
        word_par   = ^shift_q ^ data_i;
`else
        word       = {shift_q[WORD-2:0], data_i};
`endif
      end else begin
        shift_d = {shift_q[WORD-2:0], data_i};
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    // Output buffer: a completed word loads only if the slot is free or being drained now.
    if (frame_done) begin
      if (!valid_q || o_ready) begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef M_S_TO_P_PARITY_EN
        par_d   = word_par;
`endif
      end else begin
        ovr_event = 1'b1;
      end
    end else if (valid_q && o_ready) begin
      valid_d = 1'b0;
`ifdef M_S_TO_P_PARITY_EN
      par_d   = 1'b0;
`endif
    end

    ovr_d = (ovr_q & ~err_clr) | ovr_event;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking only here, so every register updates from the same pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef M_S_TO_P_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef M_S_TO_P_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy        = busy_q;
  assign overrun_err = ovr_q;
`ifdef M_S_TO_P_PARITY_EN
  assign parity_err  = par_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
